// File: rtl/ahb_master_if.sv
// AHB-Lite burst master: turns a command (read/write, address, length)
// into pipelined NONSEQ/SEQ beats with wait-state, BUSY and ERROR handling.
module ahb_master_if (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        done_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP,
    input  logic [31:0] HRDATA
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_ERR1 = 2'd3;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    localparam logic [1:0] R_OKAY  = 2'b00;
    localparam logic [1:0] R_ERROR = 2'b01;

    logic [1:0]  state_q, state_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  burst_q, burst_d;
    logic [31:0] wdata_q, wdata_d;
    logic [4:0]  left_q, left_d;
    logic        first_q, first_d;
    logic        nonseq_q, nonseq_d;
    logic        dp_q, dp_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        done_q, done_d;
    logic        done_err_q, done_err_d;

    logic        wr_ok;
    logic        addr_go;
    logic        err_hit;
    logic        dp_ok;
    logic [31:0] addr_nxt;
    logic [1:0]  htrans;

    // Write beats only go on the bus once data is offered; wr_valid is
    // expected to stay high until the beat is taken.
    assign wr_ok    = !write_q || wr_valid;
    assign addr_go  = (state_q == S_ADDR) && HREADY && wr_ok;
    assign err_hit  = dp_q && !HREADY && (HRESP == R_ERROR);
    assign dp_ok    = dp_q && HREADY && (HRESP == R_OKAY);
    assign addr_nxt = addr_q + 32'd4;

    assign cmd_ready = (state_q == S_IDLE) && !done_q;
    assign wr_ready  = addr_go && write_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign done_err  = done_err_q;
    assign HADDR     = addr_q;
    assign HTRANS    = htrans;
    assign HWRITE    = write_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = burst_q;
    assign HWDATA    = wdata_q;

    // Transfer type: stalled write beats show IDLE (first) or BUSY (later).
    always_comb begin
        htrans = T_IDLE;
        if (state_q == S_ADDR) begin
            if (!wr_ok) htrans = first_q ? T_IDLE : T_BUSY;
            else        htrans = nonseq_q ? T_NONSEQ : T_SEQ;
        end
    end

    // Next-state logic for the beat sequencer and its pipeline.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        burst_d    = burst_q;
        wdata_d    = wdata_q;
        left_d     = left_q;
        first_d    = first_q;
        nonseq_d   = nonseq_q;
        dp_d       = dp_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;
        done_err_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    write_d  = cmd_write;
                    addr_d   = cmd_addr & ~32'h3;
                    left_d   = {1'b0, cmd_len} + 5'd1;
                    burst_d  = (cmd_len == 4'd0) ? 3'b000 : 3'b001;
                    first_d  = 1'b1;
                    nonseq_d = 1'b1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                rd_valid_d = dp_ok && !write_q;
                if (err_hit) begin
                    state_d = S_ERR1;
                end else if (HREADY) begin
                    dp_d = addr_go;
                    if (addr_go) begin
                        if (write_q) wdata_d = wr_data;
                        left_d = left_q - 5'd1;
                        if (left_q == 5'd1) begin
                            state_d = S_DATA;
                        end else begin
                            addr_d   = addr_nxt;
                            first_d  = 1'b0;
                            nonseq_d = (addr_nxt[9:0] == 10'd0);
                        end
                    end
                end
            end
            S_DATA: begin
                rd_valid_d = dp_ok && !write_q;
                if (err_hit) begin
                    state_d = S_ERR1;
                end else if (dp_q && HREADY) begin
                    dp_d       = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = (HRESP == R_ERROR);
                    state_d    = S_IDLE;
                end
            end
            S_ERR1: begin
                if (HREADY) begin
                    dp_d       = 1'b0;
                    done_d     = 1'b1;
                    done_err_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
        endcase
        if (rd_valid_d) rd_data_d = HRDATA;
    end

    // State registers; reset aborts any burst without a done pulse.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            burst_q    <= 3'b000;
            wdata_q    <= 32'd0;
            left_q     <= 5'd0;
            first_q    <= 1'b0;
            nonseq_q   <= 1'b0;
            dp_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            burst_q    <= burst_d;
            wdata_q    <= wdata_d;
            left_q     <= left_d;
            first_q    <= first_d;
            nonseq_q   <= nonseq_d;
            dp_q       <= dp_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
            done_err_q <= done_err_d;
        end
    end
endmodule

// File: tb/tb_ahb_master_if.sv
// Bench for ahb_master_if: directed bursts against a small AHB slave model,
// with address/read/write scoreboards filled when each command is issued.
module tb_ahb_master_if;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        done_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic [1:0]  HRESP = 2'b00;
    logic [31:0] HRDATA;

    ahb_master_if dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .done_err(done_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int vecs = 0;
    int errs = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [31:0] exp_a[$];
    logic [1:0]  exp_t[$];
    logic [31:0] exp_r[$];
    logic [31:0] exp_w[$];
    logic [31:0] wr_idx = 32'd0;
    logic [31:0] wexp_n = 32'd0;
    logic        cur_write = 1'b0;
    logic        dp_act, dp_wr;
    logic [31:0] dp_addr;
    logic        p_valid = 1'b0;
    logic        p_hready;
    logic [1:0]  p_htrans, p_hresp;
    logic [31:0] p_haddr;

    function automatic logic [31:0] rdat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    assign HRDATA  = rdat(dp_addr);
    assign wr_data = 32'hC0DE_0000 + wr_idx;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave model: track the transfer currently in its data phase.
    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_act  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= 32'd0;
        end else if (HREADY) begin
            dp_act  <= HTRANS[1];
            dp_wr   <= HWRITE;
            dp_addr <= HADDR;
        end
    end

    always @(posedge HCLK)
        if (!HRESET && wr_valid && wr_ready) wr_idx <= wr_idx + 32'd1;

    // Bus monitor: pops scoreboards as beats complete.
    always @(negedge HCLK) begin
        if (HRESET) begin
            p_valid = 1'b0;
        end else begin
            if (HTRANS == 2'b01) busy_cnt++;
            chk("wr_ready", {31'd0, wr_ready},
                {31'd0, HTRANS[1] && HREADY && cur_write});
            if (HTRANS[1] && HREADY) begin
                if (cur_write) wr_cnt++;
                chk("aphase_expected", exp_a.size() > 0, 1);
                if (exp_a.size() > 0) begin
                    chk("haddr", HADDR, exp_a.pop_front());
                    chk("htrans", {30'd0, HTRANS}, {30'd0, exp_t.pop_front()});
                end
            end
            if (dp_act && dp_wr && HREADY && HRESP == 2'b00) begin
                chk("wbeat_expected", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) chk("hwdata", HWDATA, exp_w.pop_front());
            end
            if (rd_valid) begin
                rd_cnt++;
                chk("rbeat_expected", exp_r.size() > 0, 1);
                if (exp_r.size() > 0) chk("rd_data", rd_data, exp_r.pop_front());
            end
            if (done) done_cnt++;
            if (p_valid && !p_hready && p_htrans[1] && p_hresp == 2'b00) begin
                chk("hold_haddr", HADDR, p_haddr);
                chk("hold_htrans", {30'd0, HTRANS}, {30'd0, p_htrans});
            end
            p_valid  = 1'b1;
            p_hready = HREADY;
            p_htrans = HTRANS;
            p_hresp  = HRESP;
            p_haddr  = HADDR;
        end
    end

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [3:0] len, input int na, input int nd);
        logic [31:0] ba;
        for (int k = 0; k < 20 && cmd_ready !== 1'b1; k++) nxt();
        chk("cmd_ready_before_issue", {31'd0, cmd_ready}, 1);
        for (int b = 0; b < na; b++) begin
            ba = a + 32'(4 * b);
            exp_a.push_back(ba);
            exp_t.push_back((b == 0 || ba[9:0] == 10'd0) ? 2'b10 : 2'b11);
        end
        for (int b = 0; b < nd; b++) begin
            if (w) begin
                exp_w.push_back(32'hC0DE_0000 + wexp_n);
                wexp_n = wexp_n + 32'd1;
            end else begin
                exp_r.push_back(rdat(a + 32'(4 * b)));
            end
        end
        cur_write = w;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        nxt();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        logic seen;
        logic de;
        seen = 1'b0;
        de   = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge HCLK);
            if (done === 1'b1) begin
                seen = 1'b1;
                de   = done_err;
                break;
            end
            nxt();
        end
        if (seen) nxt();
        chk({tag, "_done"}, {31'd0, seen}, 1);
        chk({tag, "_done_err"}, {31'd0, de}, {31'd0, exp_err});
    endtask

    task automatic end_chk(input string tag);
        chk({tag, "_queues_empty"},
            exp_a.size() + exp_r.size() + exp_w.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int rd0, wr0, bz0, dc0;
        // Reset values
        @(negedge HCLK);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        chk("rst_htrans", {30'd0, HTRANS}, 0);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwrite", {31'd0, HWRITE}, 0);
        chk("rst_hsize", {29'd0, HSIZE}, 3'b010);
        chk("rst_hburst", {29'd0, HBURST}, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_done_err", {31'd0, done_err}, 0);
        nxt();
        HRESET = 1'b0;
        nxt();

        // Single read at 0x100
        issue(1'b0, 32'h100, 4'd0, 1, 1);
        @(negedge HCLK);
        chk("sr_htrans", {30'd0, HTRANS}, 2'b10);
        chk("sr_haddr", HADDR, 32'h100);
        chk("sr_hburst", {29'd0, HBURST}, 0);
        chk("sr_hsize", {29'd0, HSIZE}, 3'b010);
        chk("sr_cmd_ready_busy", {31'd0, cmd_ready}, 0);
        nxt();
        nxt();
        @(negedge HCLK);
        chk("sr_rd_valid", {31'd0, rd_valid}, 1);
        chk("sr_rd_data", rd_data, rdat(32'h100));
        chk("sr_done", {31'd0, done}, 1);
        chk("sr_done_err", {31'd0, done_err}, 0);
        nxt();
        end_chk("sr");

        // 4-beat write at 0x200, data always available
        wr0 = wr_cnt;
        wr_valid = 1'b1;
        issue(1'b1, 32'h200, 4'd3, 4, 4);
        @(negedge HCLK);
        chk("w4_hburst", {29'd0, HBURST}, 3'b001);
        chk("w4_hwrite", {31'd0, HWRITE}, 1);
        nxt();
        wait_done("w4", 1'b0);
        chk("w4_wr_ready_pulses", wr_cnt - wr0, 4);
        end_chk("w4");

        // 4-beat read at 0x300, two wait states on beat 2
        rd0 = rd_cnt;
        issue(1'b0, 32'h300, 4'd3, 4, 4);
        nxt();
        HREADY = 1'b0;
        @(negedge HCLK);
        chk("rw_haddr_w0", HADDR, 32'h304);
        chk("rw_htrans_w0", {30'd0, HTRANS}, 2'b11);
        nxt();
        @(negedge HCLK);
        chk("rw_haddr_w1", HADDR, 32'h304);
        chk("rw_htrans_w1", {30'd0, HTRANS}, 2'b11);
        nxt();
        HREADY = 1'b1;
        wait_done("rw", 1'b0);
        chk("rw_rd_pulses", rd_cnt - rd0, 4);
        end_chk("rw");

        // 3-beat write at 0x500, wr_valid low for 3 cycles before beat 2
        wr0 = wr_cnt;
        bz0 = busy_cnt;
        wr_valid = 1'b1;
        issue(1'b1, 32'h500, 4'd2, 3, 3);
        nxt();
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b0;
            @(negedge HCLK);
            chk("wb_htrans_busy", {30'd0, HTRANS}, 2'b01);
            chk("wb_haddr_held", HADDR, 32'h504);
            nxt();
        end
        wr_valid = 1'b1;
        @(negedge HCLK);
        chk("wb_htrans_seq", {30'd0, HTRANS}, 2'b11);
        nxt();
        wait_done("wb", 1'b0);
        chk("wb_busy_cycles", busy_cnt - bz0, 3);
        chk("wb_beats", wr_cnt - wr0, 3);
        end_chk("wb");
        wr_valid = 1'b0;

        // 8-beat read at 0x3F8 crossing the 1 KB boundary
        rd0 = rd_cnt;
        issue(1'b0, 32'h3F8, 4'd7, 8, 8);
        wait_done("r8", 1'b0);
        chk("r8_rd_pulses", rd_cnt - rd0, 8);
        end_chk("r8");

        // ERROR response on beat 2 of a 4-beat read
        rd0 = rd_cnt;
        issue(1'b0, 32'h600, 4'd3, 2, 1);
        nxt();
        nxt();
        HREADY = 1'b0;
        HRESP  = 2'b01;
        nxt();
        HREADY = 1'b1;
        @(negedge HCLK);
        chk("er_htrans_idle", {30'd0, HTRANS}, 2'b00);
        nxt();
        HRESP = 2'b00;
        @(negedge HCLK);
        chk("er_done", {31'd0, done}, 1);
        chk("er_done_err", {31'd0, done_err}, 1);
        nxt();
        @(negedge HCLK);
        chk("er_cmd_ready", {31'd0, cmd_ready}, 1);
        nxt();
        chk("er_rd_pulses", rd_cnt - rd0, 1);
        end_chk("er");

        // Reset in the middle of a read burst
        issue(1'b0, 32'h700, 4'd3, 1, 0);
        nxt();
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("mr_htrans", {30'd0, HTRANS}, 0);
        chk("mr_haddr", HADDR, 0);
        chk("mr_cmd_ready", {31'd0, cmd_ready}, 1);
        dc0 = done_cnt;
        nxt();
        HRESET = 1'b0;
        nxt();
        nxt();
        nxt();
        chk("mr_no_done", done_cnt, dc0);
        end_chk("mr");

        // Recovery: single read after the abort
        issue(1'b0, 32'h40, 4'd0, 1, 1);
        wait_done("rc", 1'b0);
        end_chk("rc");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
